display_refresh_scheduler: RTL and testbench

//  Sequences the 4-digit multiplexed 7-segment path: digit slot timing, active-low anode drive,
//  per-slot nibble selection, and a tear-free update of the displayed 16-bit value.

---
 rtl/display_refresh_scheduler.sv | 81 ++++++++
 tb/tb_display_refresh_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/display_refresh_scheduler.sv
// display_refresh_scheduler: digit-slot timing, guarded active-low anode drive and frame-synchronous value commit for a 4-digit 7-seg display
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_value_in     16-bit value, sampled only at a frame-boundary commit
//   i_load_req     level request to commit i_value_in, held until o_load_ack
//   o_load_ack     one-cycle pulse after a commit (coincides with o_frame_start)
//   i_lz_suppress  1 = blank leading zero digits
//   i_digit_en     per-digit enable mask, bit i = digit i
//   o_digit_idx    digit currently scheduled (0 = rightmost)
//   o_nibble_out   shadow nibble of the scheduled digit
//   o_anodes       active-low digit enables
//   o_frame_start  high in the first cycle of the digit-0 slot
module display_refresh_scheduler #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [15:0] i_value_in,
    input  logic        i_load_req,
    output logic        o_load_ack,
    input  logic        i_lz_suppress,
    input  logic [3:0]  i_digit_en,
    output logic [1:0]  o_digit_idx,
    output logic [3:0]  o_nibble_out,
    output logic [3:0]  o_anodes,
    output logic        o_frame_start
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] LAST     = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_M1 = PW'(GUARD_CYCLES - 1);
    localparam logic [PW-1:0] ONE      = PW'(1);

    typedef enum logic {GUARD, DRIVE} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [1:0]      r_digit_idx;
    logic [15:0]     r_shadow;
    logic            r_load_ack;
    logic            w_wrap;
    logic            w_commit;
    logic [3:0]      w_lz_blank;
    logic [3:0]      w_sel;

    assign w_wrap   = (r_presc == LAST);
    assign w_commit = w_wrap && (r_digit_idx == 2'd3) && i_load_req;

    // Blanking chains from the most significant digit; digit 0 always shows so a zero value reads "0".
    assign w_lz_blank[3] = i_lz_suppress && (r_shadow[15:12] == 4'h0);
    assign w_lz_blank[2] = w_lz_blank[3] && (r_shadow[11:8] == 4'h0);
    assign w_lz_blank[1] = w_lz_blank[2] && (r_shadow[7:4] == 4'h0);
    assign w_lz_blank[0] = 1'b0;

    assign w_sel = 4'b0001 << r_digit_idx;

    // Enable mask and blanking act combinationally so changes land in the same cycle.
    assign o_anodes      = (r_state == DRIVE) ? ~(w_sel & i_digit_en & ~w_lz_blank) : 4'hF;
    assign o_nibble_out  = r_shadow[{r_digit_idx, 2'b00} +: 4];
    assign o_digit_idx   = r_digit_idx;
    assign o_load_ack    = r_load_ack;
    assign o_frame_start = (r_presc == '0) && (r_digit_idx == 2'd0);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= GUARD;
            r_presc     <= '0;
            r_digit_idx <= 2'd0;
            r_shadow    <= 16'h0000;
            r_load_ack  <= 1'b0;
        end else begin
            r_presc     <= w_wrap ? '0 : r_presc + ONE;
            r_digit_idx <= w_wrap ? r_digit_idx + 2'd1 : r_digit_idx;
            r_state     <= w_wrap ? GUARD : (r_presc == GUARD_M1) ? DRIVE : r_state;
            r_load_ack  <= w_commit;
            if (w_commit)
                r_shadow <= i_value_in;
        end
    end
endmodule

// File: tb/tb_display_refresh_scheduler.sv
// tb_display_refresh_scheduler: directed self-checking bench for display_refresh_scheduler with REFRESH_DIV=8, GUARD_CYCLES=2
module tb_display_refresh_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        lz = 1'b0;
    logic [15:0] val = 16'h0000;
    logic [3:0]  en = 4'hF;
    logic        ack;
    logic        fs;
    logic [1:0]  idx;
    logic [3:0]  nib;
    logic [3:0]  an;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    display_refresh_scheduler #(.REFRESH_DIV(8), .GUARD_CYCLES(2)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_value_in(val),
        .i_load_req(req),
        .o_load_ack(ack),
        .i_lz_suppress(lz),
        .i_digit_en(en),
        .o_digit_idx(idx),
        .o_nibble_out(nib),
        .o_anodes(an),
        .o_frame_start(fs)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [1:0] ei;
        logic [3:0] ea;
        req = 1'b0; val = 16'h0; lz = 1'b0; en = 4'hF;
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            ei = 2'((c / 8) % 4);
            ea = ((c % 8) < 2) ? 4'hF : ~(4'b0001 << ei);
            tests++; if (idx !== ei) begin fails++; $display("FAIL reset_idx c=%0d got %0d want %0d", c, idx, ei); end
            tests++; if (an !== ea) begin fails++; $display("FAIL reset_anodes c=%0d got %b want %b", c, an, ea); end
            tests++; if (nib !== 4'h0) begin fails++; $display("FAIL reset_nibble c=%0d got %h want 0", c, nib); end
            tests++; if (fs !== (c % 32 == 0)) begin fails++; $display("FAIL reset_frame_start c=%0d got %b", c, fs); end
            tests++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack c=%0d got %b want 0", c, ack); end
            if (c < 32) tick();
        end
    endtask

    task automatic test_load;
        logic       chk;
        logic [3:0] ea;
        logic [3:0] enib;
        req = 1'b1; val = 16'h1234; lz = 1'b0; en = 4'hF;
        do_reset();
        for (int c = 0; c <= 63; c++) begin
            tests++; if (ack !== (c == 32)) begin fails++; $display("FAIL load_ack c=%0d got %b", c, ack); end
            chk = 1'b1;
            if (c >= 2 && c <= 7) begin ea = 4'b1110; enib = 4'h0; end
            else if (c >= 34 && c <= 39) begin ea = 4'b1110; enib = 4'h4; end
            else if (c >= 42 && c <= 47) begin ea = 4'b1101; enib = 4'h3; end
            else if (c >= 50 && c <= 55) begin ea = 4'b1011; enib = 4'h2; end
            else if (c >= 58 && c <= 63) begin ea = 4'b0111; enib = 4'h1; end
            else begin chk = 1'b0; ea = 4'hF; enib = 4'h0; end
            if (chk) begin
                tests++; if (an !== ea) begin fails++; $display("FAIL load_anodes c=%0d got %b want %b", c, an, ea); end
                tests++; if (nib !== enib) begin fails++; $display("FAIL load_nibble c=%0d got %h want %h", c, nib, enib); end
            end
            if (c == 32) begin
                tests++; if (fs !== 1'b1) begin fails++; $display("FAIL load_frame_start got %b want 1", fs); end
            end
            if (c < 63) tick();
        end
        req = 1'b0;
    endtask

    task automatic test_lz;
        logic [1:0] ei;
        logic       g;
        logic [3:0] ea;
        logic [3:0] enib;
        req = 1'b1; val = 16'h0050; lz = 1'b1; en = 4'hF;
        do_reset();
        for (int c = 0; c <= 95; c++) begin
            ei = 2'((c / 8) % 4);
            g = (c % 8) < 2;
            if (c >= 32 && c < 64) ea = g ? 4'hF : (ei == 2'd0) ? 4'b1110 : (ei == 2'd1) ? 4'b1101 : 4'hF;
            else ea = g ? 4'hF : (ei == 2'd0) ? 4'b1110 : 4'hF;
            enib = (c >= 32 && c < 64 && ei == 2'd1) ? 4'h5 : 4'h0;
            tests++; if (an !== ea) begin fails++; $display("FAIL lz_anodes c=%0d got %b want %b", c, an, ea); end
            tests++; if (nib !== enib) begin fails++; $display("FAIL lz_nibble c=%0d got %h want %h", c, nib, enib); end
            tests++; if (ack !== (c == 32 || c == 64)) begin fails++; $display("FAIL lz_ack c=%0d got %b", c, ack); end
            if (c == 84) begin
                lz = 1'b0; #1;
                tests++; if (an !== 4'b1011) begin fails++; $display("FAIL lz_off_same_cycle got %b want 1011", an); end
                lz = 1'b1; #1;
                tests++; if (an !== 4'hF) begin fails++; $display("FAIL lz_on_same_cycle got %b want 1111", an); end
            end
            if (c == 32 || c == 64) req = 1'b0;
            if (c == 63) begin val = 16'h0000; req = 1'b1; end
            if (c < 95) tick();
        end
        lz = 1'b0;
    endtask

    task automatic test_digit_en;
        logic [1:0] ei;
        logic [3:0] ea;
        req = 1'b0; lz = 1'b0; en = 4'b0101;
        do_reset();
        for (int c = 0; c <= 31; c++) begin
            ei = 2'((c / 8) % 4);
            ea = ((c % 8) < 2) ? 4'hF : (ei == 2'd0) ? 4'b1110 : (ei == 2'd2) ? 4'b1011 : 4'hF;
            tests++; if (an !== ea) begin fails++; $display("FAIL en_anodes c=%0d got %b want %b", c, an, ea); end
            tests++; if (idx !== ei) begin fails++; $display("FAIL en_idx c=%0d got %0d want %0d", c, idx, ei); end
            if (c == 12) begin
                en = 4'hF; #1;
                tests++; if (an !== 4'b1101) begin fails++; $display("FAIL en_same_cycle got %b want 1101", an); end
                en = 4'b0101; #1;
                tests++; if (an !== 4'hF) begin fails++; $display("FAIL en_restore got %b want 1111", an); end
            end
            if (c < 31) tick();
        end
        en = 4'hF;
    endtask

    task automatic test_req_pulse;
        lz = 1'b0; en = 4'hF; val = 16'hBEEF;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            req = (c >= 5 && c <= 20);
            tests++; if (ack !== 1'b0) begin fails++; $display("FAIL pulse_ack c=%0d got %b want 0", c, ack); end
            tests++; if (nib !== 4'h0) begin fails++; $display("FAIL pulse_nibble c=%0d got %h want 0", c, nib); end
            if (c < 40) tick();
        end
        req = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [1:0] ei;
        logic [3:0] enib;
        lz = 1'b0; en = 4'hF; req = 1'b1;
        do_reset();
        for (int c = 0; c <= 64; c++) begin
            if (c <= 31) val = 16'hA500 + 16'(c);
            if (c == 32) val = 16'h1111;
            ei = 2'((c / 8) % 4);
            tests++; if (ack !== (c == 32 || c == 64)) begin fails++; $display("FAIL b2b_ack c=%0d got %b", c, ack); end
            if (c >= 32 && c < 64) begin
                enib = (ei == 2'd0) ? 4'hF : (ei == 2'd1) ? 4'h1 : (ei == 2'd2) ? 4'h5 : 4'hA;
                tests++; if (nib !== enib) begin fails++; $display("FAIL b2b_nibble c=%0d got %h want %h", c, nib, enib); end
            end
            if (c == 64) begin
                tests++; if (nib !== 4'h1) begin fails++; $display("FAIL b2b_recommit got %h want 1", nib); end
            end
            if (c < 64) tick();
        end
        req = 1'b0;
    endtask

    task automatic test_reset_mid;
        lz = 1'b0; en = 4'hF; val = 16'hFFFF; req = 1'b1;
        do_reset();
        for (int c = 0; c < 45; c++) tick();
        tests++; if (an !== 4'b1101) begin fails++; $display("FAIL mid_pre_anodes got %b want 1101", an); end
        tests++; if (nib !== 4'hF) begin fails++; $display("FAIL mid_pre_nibble got %h want f", nib); end
        rst = 1'b1;
        tick();
        tests++; if (an !== 4'hF) begin fails++; $display("FAIL mid_anodes got %b want 1111", an); end
        tests++; if (idx !== 2'd0) begin fails++; $display("FAIL mid_idx got %0d want 0", idx); end
        tests++; if (nib !== 4'h0) begin fails++; $display("FAIL mid_nibble got %h want 0", nib); end
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL mid_ack got %b want 0", ack); end
        tests++; if (fs !== 1'b1) begin fails++; $display("FAIL mid_frame_start got %b want 1", fs); end
        rst = 1'b0; req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tests++; if (ack !== 1'b0) begin fails++; $display("FAIL mid_post_ack k=%0d got %b", k, ack); end
            tests++; if (nib !== 4'h0) begin fails++; $display("FAIL mid_post_nibble k=%0d got %h want 0", k, nib); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_lz();
        test_digit_en();
        test_req_pulse();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
